// File: rtl/fetch_unit_if.sv
// Bundle of the instruction-memory handshake and the decode-side handoff for fetch_unit.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic [31:0] pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, halted,
    input  imem_ack, imem_rdata, instr_ready, branch, zero
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, halted,
    output imem_ack, imem_rdata, instr_ready, branch, zero
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: one outstanding req/ack fetch at pc, holds the word for decode
// and steps pc (sequential, beq, j) when decode accepts it; a halt opcode parks the stage.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam logic [5:0] OpJump = 6'b000010;

  typedef enum logic [1:0] {StFetch, StWait, StHold, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        armed_q;

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] jump_target;
  logic        ack_taken;
  logic        accept;

  // The first cycle after reset sits in FETCH without a request, so a late ack left over
  // from an abandoned transfer cannot be mistaken for the new fetch.
  assign bus.imem_req    = ((state_q == StFetch) && armed_q) || (state_q == StWait);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.instr_valid = (state_q == StHold);
  assign bus.pc          = pc_q;
  assign bus.halted      = (state_q == StHalt);

  assign ack_taken   = bus.imem_req && bus.imem_ack;
  assign accept      = (state_q == StHold) && bus.instr_ready;
  assign pc_plus4    = pc_q + 32'd4;
  assign br_offset   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StFetch: begin
        if (ack_taken) begin
          instr_d = bus.imem_rdata;
          state_d = StHold;
        end else if (armed_q) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (ack_taken) begin
          instr_d = bus.imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (accept) begin
          if (instr_q[31:26] == HALT_OPCODE) begin
            state_d = StHalt;
          end else begin
            state_d = StFetch;
            if (instr_q[31:26] == OpJump) begin
              pc_d = jump_target;
            end else if (bus.branch && bus.zero) begin
              pc_d = pc_plus4 + br_offset;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      armed_q <= 1'b1;
    end
  end

endmodule
